// File: rtl/shift_clk_gen_param.sv
// Serial shift clock generator with runtime divider, bit count and idle polarity.
// Emits lead/trail strobes aligned to shiftClk changes and frames each transfer with busy/done.
module shift_clk_gen_param #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             enable,
  input  logic             cpol,
  input  logic [DIV_W-1:0] divHalf,
  input  logic [CNT_W-1:0] numBits,
  output logic             shiftClk,
  output logic             leadEdge,
  output logic             trailEdge,
  output logic [CNT_W-1:0] bitIdx,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] hc, hc_nxt, div_q, div_nxt;
  logic [CNT_W-1:0] nb_q, nb_nxt, idx_nxt;
  logic             cpol_q, cpol_nxt;
  logic             clk_nxt, lead_nxt, trail_nxt, busy_nxt, done_nxt;
  logic             half_end, returning, last_bit;

  assign half_end  = enable && (hc == div_q);
  assign returning = (shiftClk != cpol_q);
  assign last_bit  = (bitIdx == nb_q - CNT_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      hc        <= '0;
      div_q     <= '0;
      nb_q      <= '0;
      cpol_q    <= 1'b0;
      shiftClk  <= 1'b0;
      leadEdge  <= 1'b0;
      trailEdge <= 1'b0;
      bitIdx    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      hc        <= hc_nxt;
      div_q     <= div_nxt;
      nb_q      <= nb_nxt;
      cpol_q    <= cpol_nxt;
      shiftClk  <= clk_nxt;
      leadEdge  <= lead_nxt;
      trailEdge <= trail_nxt;
      bitIdx    <= idx_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !abort && (numBits != '0)) state_nxt = RUN;
      RUN:     if (abort || (half_end && returning && last_bit)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Abort outranks enable and any pending edge; the final trail edge and done share a cycle.
  always_comb begin
    hc_nxt    = hc;
    div_nxt   = div_q;
    nb_nxt    = nb_q;
    cpol_nxt  = cpol_q;
    clk_nxt   = shiftClk;
    lead_nxt  = 1'b0;
    trail_nxt = 1'b0;
    idx_nxt   = bitIdx;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        clk_nxt = cpol_q;
        if (start && !abort) begin
          if (numBits != '0) begin
            div_nxt  = divHalf;
            nb_nxt   = numBits;
            cpol_nxt = cpol;
            hc_nxt   = '0;
            idx_nxt  = '0;
            busy_nxt = 1'b1;
            clk_nxt  = cpol;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          hc_nxt   = '0;
          clk_nxt  = cpol_q;
          idx_nxt  = '0;
          busy_nxt = 1'b0;
        end else if (half_end) begin
          hc_nxt    = '0;
          clk_nxt   = ~shiftClk;
          lead_nxt  = ~returning;
          trail_nxt = returning;
          if (returning) begin
            if (last_bit) begin
              busy_nxt = 1'b0;
              done_nxt = 1'b1;
              idx_nxt  = '0;
            end else begin
              idx_nxt = bitIdx + CNT_W'(1);
            end
          end
        end else if (enable) begin
          hc_nxt = hc + DIV_W'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_shift_clk_gen_param.sv
// Bench for shift_clk_gen_param: directed scenarios plus random traffic against a
// transfer-level model that derives outputs from the count of enabled RUN cycles.
module tb_shift_clk_gen_param;
  logic       clk = 1'b0;
  logic       reset, start, abort, enable, cpol;
  logic [7:0] divHalf;
  logic [5:0] numBits;
  logic       shiftClk, leadEdge, trailEdge, busy, done;
  logic [5:0] bitIdx;
  logic [10:0] act;

  int n_cmp = 0;
  int n_fail = 0;

  bit m_busy, m_cpol, m_lead, m_trail, m_done;
  int m_e, m_d, m_n;

  always #5 clk = ~clk;

  shift_clk_gen_param #(.DIV_W(8), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .enable(enable),
    .cpol(cpol), .divHalf(divHalf), .numBits(numBits), .shiftClk(shiftClk),
    .leadEdge(leadEdge), .trailEdge(trailEdge), .bitIdx(bitIdx), .busy(busy), .done(done)
  );

  assign act = {shiftClk, leadEdge, trailEdge, bitIdx, busy, done};

  function automatic void model_reset();
    m_busy = 0; m_cpol = 0; m_lead = 0; m_trail = 0; m_done = 0;
    m_e = 0; m_d = 0; m_n = 0;
  endfunction

  // Half-periods completed = enabled cycles / (divHalf+1); odd count means away from idle.
  function automatic logic [10:0] exp_vec();
    int  tog;
    logic c;
    logic [5:0] idx;
    tog = m_busy ? m_e / (m_d + 1) : 0;
    c   = m_busy ? (m_cpol ^ tog[0]) : m_cpol;
    idx = 6'(tog / 2);
    return {c, m_lead, m_trail, idx, m_busy, m_done};
  endfunction

  task automatic step(input bit s, input bit a, input bit en, input bit cp,
                      input logic [7:0] dv, input logic [5:0] nb);
    int tog;
    start = s; abort = a; enable = en; cpol = cp; divHalf = dv; numBits = nb;
    @(posedge clk);
    m_lead = 0; m_trail = 0; m_done = 0;
    if (!m_busy) begin
      if (s && !a) begin
        if (nb != 0) begin
          m_busy = 1; m_cpol = cp; m_d = dv; m_n = nb; m_e = 0;
        end else m_done = 1;
      end
    end else if (a) begin
      m_busy = 0;
    end else if (en) begin
      m_e++;
      if (m_e % (m_d + 1) == 0) begin
        tog = m_e / (m_d + 1);
        if (tog % 2 == 1) m_lead = 1; else m_trail = 1;
        if (tog == 2 * m_n) begin m_busy = 0; m_done = 1; end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 0; abort = 0; enable = 1; cpol = 0; divHalf = 0; numBits = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (act !== 11'h0) begin n_fail++; $display("FAIL reset_state act=%h exp=%h", act, 11'h0); end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    int leads = 0, trails = 0, done_at = -1, busy_n = 0;
    step(1, 0, 1, 0, 8'd0, 6'd8);
    n_cmp++;
    if (act !== exp_vec()) begin n_fail++; $display("FAIL basic_accept act=%h exp=%h", act, exp_vec()); end
    busy_n += busy;
    for (int k = 1; k <= 20; k++) begin
      step(0, 0, 1, 1'($urandom), 8'($urandom), 6'($urandom));
      n_cmp++;
      if (act !== exp_vec()) begin n_fail++; $display("FAIL basic_cyc%0d act=%h exp=%h", k, act, exp_vec()); end
      leads += leadEdge; trails += trailEdge; busy_n += busy;
      if (done) done_at = k;
    end
    n_cmp++;
    if (leads != 8 || trails != 8 || done_at != 16 || busy_n != 16) begin
      n_fail++;
      $display("FAIL basic_totals lead=%0d trail=%0d done_at=%0d busy=%0d exp 8/8/16/16", leads, trails, done_at, busy_n);
    end
  endtask

  task automatic test_cpol1();
    int busy_n = 0;
    step(1, 0, 1, 1, 8'd3, 6'd2);
    busy_n += busy;
    n_cmp++;
    if (shiftClk !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL cpol1_accept clk=%b busy=%b exp 1/1", shiftClk, busy); end
    for (int k = 1; k <= 20; k++) begin
      step(0, 0, 1, 0, 8'd0, 6'd9);
      n_cmp++;
      if (act !== exp_vec()) begin n_fail++; $display("FAIL cpol1_cyc%0d act=%h exp=%h", k, act, exp_vec()); end
      busy_n += busy;
    end
    n_cmp++;
    if (busy_n != 16 || shiftClk !== 1'b1) begin n_fail++; $display("FAIL cpol1_busy busy=%0d clk=%b exp 16/1", busy_n, shiftClk); end
  endtask

  task automatic test_zero_bits();
    logic prev;
    prev = shiftClk;
    step(1, 0, 1, ~prev, 8'd2, 6'd0);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || shiftClk !== prev) begin
      n_fail++; $display("FAIL zero_done done=%b busy=%b clk=%b exp 1/0/%b", done, busy, shiftClk, prev);
    end
    for (int k = 1; k <= 5; k++) begin
      step(0, 0, 1, ~prev, 8'd0, 6'd0);
      n_cmp++;
      if (act !== exp_vec() || shiftClk !== prev) begin n_fail++; $display("FAIL zero_cyc%0d act=%h exp=%h", k, act, exp_vec()); end
    end
  endtask

  task automatic test_stall();
    int busy_n = 0;
    logic [6:0] frozen = '0;
    step(1, 0, 1, 0, 8'd1, 6'd4);
    busy_n += busy;
    for (int k = 1; k <= 30; k++) begin
      step(0, 0, !(k >= 6 && k <= 10), 0, 8'd1, 6'd4);
      n_cmp++;
      if (act !== exp_vec()) begin n_fail++; $display("FAIL stall_cyc%0d act=%h exp=%h", k, act, exp_vec()); end
      busy_n += busy;
      if (k == 5) frozen = {shiftClk, bitIdx};
      if (k >= 6 && k <= 10) begin
        n_cmp++;
        if ({shiftClk, bitIdx} !== frozen || leadEdge || trailEdge) begin
          n_fail++; $display("FAIL stall_frozen%0d act=%h exp=%h", k, {shiftClk, bitIdx}, frozen);
        end
      end
    end
    n_cmp++;
    if (busy_n != 21) begin n_fail++; $display("FAIL stall_length busy=%0d exp=21", busy_n); end
  endtask

  task automatic test_abort();
    int leads = 0, k = 0, dones = 0;
    step(1, 0, 1, 1, 8'd1, 6'd6);
    while (leads < 3 && k < 100) begin
      step(0, 0, 1, 1, 8'd1, 6'd6);
      leads += leadEdge; k++;
    end
    n_cmp++;
    if (leads != 3) begin n_fail++; $display("FAIL abort_leads got=%0d exp=3", leads); end
    step(0, 1, 1, 0, 8'd1, 6'd6);
    n_cmp++;
    if (shiftClk !== 1'b1 || busy !== 1'b0 || bitIdx !== 6'd0 || done || leadEdge || trailEdge) begin
      n_fail++; $display("FAIL abort_state act=%h exp=%h", act, {1'b1, 10'h0});
    end
    for (int j = 0; j < 6; j++) begin
      step(0, 1, 1, 0, 8'd0, 6'd3);
      dones += done;
      n_cmp++;
      if (act !== exp_vec()) begin n_fail++; $display("FAIL abort_idle%0d act=%h exp=%h", j, act, exp_vec()); end
    end
    n_cmp++;
    if (dones != 0) begin n_fail++; $display("FAIL abort_nodone dones=%0d exp=0", dones); end
  endtask

  task automatic test_reset_b2b();
    int k;
    step(1, 0, 1, 1, 8'd2, 6'd3);
    repeat (7) step(0, 0, 1, 1, 8'd2, 6'd3);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (act !== 11'h0) begin n_fail++; $display("FAIL midreset act=%h exp=%h", act, 11'h0); end
    model_reset();
    start = 0;
    @(posedge clk);
    #1 reset = 1'b1;
    step(1, 0, 1, 0, 8'd0, 6'd2);
    k = 0;
    while (!done && k < 50) begin
      step(0, 0, 1, 0, 8'd0, 6'd2);
      n_cmp++;
      if (act !== exp_vec()) begin n_fail++; $display("FAIL restart_cyc%0d act=%h exp=%h", k, act, exp_vec()); end
      k++;
    end
    n_cmp++;
    if (!done) begin n_fail++; $display("FAIL restart_timeout done=%b exp=1", done); end
    step(1, 0, 1, 1, 8'd1, 6'd3);
    n_cmp++;
    if (busy !== 1'b1 || shiftClk !== 1'b1 || bitIdx !== 6'd0) begin
      n_fail++; $display("FAIL b2b_accept busy=%b clk=%b idx=%0d exp 1/1/0", busy, shiftClk, bitIdx);
    end
    for (int j = 0; j < 26; j++) begin
      step(0, 0, 1, 0, 8'd0, 6'd1);
      n_cmp++;
      if (act !== exp_vec()) begin n_fail++; $display("FAIL b2b_cyc%0d act=%h exp=%h", j, act, exp_vec()); end
    end
  endtask

  task automatic test_maxdiv();
    int busy_n = 0, lead_at = -1;
    step(1, 0, 1, 0, 8'hFF, 6'd1);
    busy_n += busy;
    for (int k = 1; k <= 520; k++) begin
      step(0, 0, 1, 0, 8'h00, 6'd1);
      busy_n += busy;
      if (leadEdge) lead_at = k;
    end
    n_cmp++;
    if (busy_n != 512 || lead_at != 256) begin
      n_fail++; $display("FAIL maxdiv busy=%0d lead_at=%0d exp 512/256", busy_n, lead_at);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0, $urandom_range(0, 7) != 0,
           1'($urandom), 8'($urandom_range(0, 3)), 6'($urandom_range(0, 4)));
      n_cmp++;
      if (act !== exp_vec()) begin n_fail++; $display("FAIL random_cyc%0d act=%h exp=%h", k, act, exp_vec()); end
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_basic();
    test_cpol1();
    test_zero_bits();
    test_stall();
    test_abort();
    test_reset_b2b();
    test_maxdiv();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
